// File: rtl/zx_ula_core_if.sv
// Z80-side bus of the ULA: address, strobes, split data paths and the ULA's xd drive enable.
// The master is the CPU side, the slave is the ULA.
interface zx_ula_core_if;
   logic [15:0] xa;
   logic [7:0]  xd_wr;   // data presented by the CPU on xd
   logic [7:0]  xd_rd;   // data the ULA puts on xd while dout is high
   logic        dout;
   logic        n_rd;
   logic        n_wr;
   logic        n_mreq;
   logic        n_m1;
   logic        n_rfsh;
   logic        n_iorqge;

   modport master (
      output xa, xd_wr, n_rd, n_wr, n_mreq, n_m1, n_rfsh, n_iorqge,
      input  xd_rd, dout
   );

   modport slave (
      input  xa, xd_wr, n_rd, n_wr, n_mreq, n_m1, n_rfsh, n_iorqge,
      output xd_rd, dout
   );
endinterface

// File: rtl/zx_ula_core.sv
// ZX Spectrum 128/512K ULA core without video: CPU clock, frame INT, paging, ports #FE/#7FFD/#1F, magic NMI.
// Define ZX_ULA_SD_EN to add the Z-controller SPI port (#77 control, #57 data).
module zx_ula_core #(
   parameter int H_TSTATES = 224,
   parameter int V_LINES   = 312,
   parameter int INT_LEN   = 32
) (
   input  logic        clk28_i,
   input  logic        rst_i,
   output logic        clkcpu_o,
   zx_ula_core_if.slave cpu_if,
   output logic [18:0] va_o,
   input  logic [7:0]  vd_i,
   output logic [7:0]  vd_o,
   output logic        vdout_o,
   output logic [3:0]  ra_o,
   output logic        n_romcs_o,
   output logic        n_vrd_o,
   output logic        n_vwr_o,
   output logic        n_int_o,
   output logic        n_nmi_o,
   input  logic        n_magic_i,
   input  logic        tape_in_i,
   input  logic [4:0]  kd_i,
   input  logic        n_joy_b2_i,
   input  logic        sd_cd_i,
   input  logic        sd_miso_i,
   output logic        sd_mosi_o,
   output logic        sd_sck_o,
   output logic        sd_cs_n_o,
   output logic [2:0]  border_o,
   output logic        beeper_o
);
   localparam int HC_W = $clog2(H_TSTATES);
   localparam int VC_W = $clog2(V_LINES);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TSTATES - 1);
   localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_LINES - 1);
   localparam logic [HC_W-1:0] INT_END = HC_W'(INT_LEN);

   logic [2:0]      cnt_q, cnt_d;
   logic [HC_W-1:0] hc_q, hc_d;
   logic [VC_W-1:0] vc_q, vc_d;
   logic            int_n_q, int_n_d;
   logic [7:0]      p7ffd_q;
   logic [2:0]      border_q;
   logic            beeper_q;
   logic            mg_s1_q, mg_s2_q, mg_prev_q;
   logic            nmi_pend_q, nmi_pend_d;
   logic            nmi_edge_s, nmi_clr_s;
   logic            mem_s, rom_s, ram_s, ram_rd_s;
   logic            io_s, io_rd_s, io_wr_s;
   logic            sel_fe_s, sel_7ffd_s, sel_1f_s;
   logic [4:0]      page_s;
   logic            port_rd_s;
   logic [7:0]      port_data_s;
   logic            unused_p7ffd_s;

   // Frame timing: T-state tick every 8 clk28, line and frame counters, INT window
   always_comb begin
      cnt_d = cnt_q + 3'd1;
      hc_d  = hc_q;
      vc_d  = vc_q;
      if (cnt_q == 3'd7) begin
         if (hc_q == HC_LAST) begin
            hc_d = {HC_W{1'b0}};
            if (vc_q == VC_LAST) begin
               vc_d = {VC_W{1'b0}};
            end else begin
               vc_d = vc_q + VC_W'(1);
            end
         end else begin
            hc_d = hc_q + HC_W'(1);
         end
      end else begin
         hc_d = hc_q;
         vc_d = vc_q;
      end
      int_n_d = ~((vc_d == {VC_W{1'b0}}) && (hc_d < INT_END));
   end

   // Counter and INT registers
   always_ff @(posedge clk28_i) begin
      if (rst_i) begin
         cnt_q   <= 3'd0;
         hc_q    <= {HC_W{1'b0}};
         vc_q    <= {VC_W{1'b0}};
         int_n_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         int_n_q <= int_n_d;
      end
   end

   assign clkcpu_o = cnt_q[2];
   assign n_int_o  = int_n_q;

   assign mem_s    = ~cpu_if.n_mreq & cpu_if.n_rfsh;
   assign rom_s    = mem_s & (cpu_if.xa[15:14] == 2'b00);
   assign ram_s    = mem_s & (cpu_if.xa[15:14] != 2'b00);
   assign ram_rd_s = ram_s & ~cpu_if.n_rd;
   assign io_s     = ~cpu_if.n_iorqge & cpu_if.n_m1;
   assign io_rd_s  = io_s & ~cpu_if.n_rd;
   assign io_wr_s  = io_s & ~cpu_if.n_wr;

   assign sel_fe_s   = ~cpu_if.xa[0];
   assign sel_7ffd_s = ~cpu_if.xa[15] & ~cpu_if.xa[1] & cpu_if.xa[0];
   assign sel_1f_s   = (cpu_if.xa[7:0] == 8'h1F);

   // Bank select for the CPU window
   always_comb begin
      case (cpu_if.xa[15:14])
         2'b01:   page_s = 5'd5;
         2'b10:   page_s = 5'd2;
         2'b11:   page_s = {p7ffd_q[7:6], p7ffd_q[2:0]};
         default: page_s = 5'd0;
      endcase
   end

   assign va_o           = {page_s, cpu_if.xa[13:0]};
   assign ra_o           = {3'b000, p7ffd_q[4]};
   assign n_romcs_o      = ~(rom_s & ~cpu_if.n_rd);
   assign n_vrd_o        = ~ram_rd_s;
   assign n_vwr_o        = ~(ram_s & ~cpu_if.n_wr);
   assign vdout_o        = ram_s & ~cpu_if.n_wr;
   assign vd_o           = cpu_if.xd_wr;
   assign unused_p7ffd_s = p7ffd_q[3];

   // Paging and #FE output registers; bit 5 of #7FFD freezes further paging writes
   always_ff @(posedge clk28_i) begin
      if (rst_i) begin
         p7ffd_q  <= 8'h00;
         border_q <= 3'd0;
         beeper_q <= 1'b0;
      end else begin
         if (io_wr_s && sel_7ffd_s && !p7ffd_q[5]) begin
            p7ffd_q <= cpu_if.xd_wr;
         end
         if (io_wr_s && sel_fe_s) begin
            border_q <= cpu_if.xd_wr[2:0];
            beeper_q <= cpu_if.xd_wr[4];
         end
      end
   end

   assign border_o = border_q;
   assign beeper_o = beeper_q;

   assign nmi_edge_s = mg_prev_q & ~mg_s2_q;
   assign nmi_clr_s  = ~cpu_if.n_m1 & ~cpu_if.n_mreq & ~cpu_if.n_rd & (cpu_if.xa == 16'h0066);

   // A fresh button edge takes priority over the acknowledge fetch
   always_comb begin
      if (nmi_edge_s) begin
         nmi_pend_d = 1'b1;
      end else if (nmi_clr_s) begin
         nmi_pend_d = 1'b0;
      end else begin
         nmi_pend_d = nmi_pend_q;
      end
   end

   // Magic button synchronizer, edge history and pending flag
   always_ff @(posedge clk28_i) begin
      if (rst_i) begin
         mg_s1_q    <= 1'b1;
         mg_s2_q    <= 1'b1;
         mg_prev_q  <= 1'b1;
         nmi_pend_q <= 1'b0;
      end else begin
         mg_s1_q    <= n_magic_i;
         mg_s2_q    <= mg_s1_q;
         mg_prev_q  <= mg_s2_q;
         nmi_pend_q <= nmi_pend_d;
      end
   end

   assign n_nmi_o = ~nmi_pend_q;

`ifdef ZX_ULA_SD_EN
   typedef enum logic {SPI_IDLE = 1'b0, SPI_XFER = 1'b1} spi_state_t;
   spi_state_t spi_state_q;
   logic       sel_77_s, sel_57_s, acc57_s, start_s;
   logic       acc57_q, sck_q, cs_n_q;
   logic [3:0] ph_q;
   logic [7:0] tx_q, rx_sh_q, rx_byte_q, rd_hold_q, rd57_data_s;

   assign sel_77_s = (cpu_if.xa[7:0] == 8'h77);
   assign sel_57_s = (cpu_if.xa[7:0] == 8'h57);
   assign acc57_s  = io_s & sel_57_s & (~cpu_if.n_rd | ~cpu_if.n_wr);
   assign start_s  = acc57_s & ~acc57_q;
   // Hold the byte seen at the start of a read so the transfer it launches cannot change it mid-cycle
   assign rd57_data_s = acc57_q ? rd_hold_q : rx_byte_q;

   // SPI engine: sck toggles every clk28, MISO taken on the rising half, MOSI shifted on the falling half
   always_ff @(posedge clk28_i) begin
      if (rst_i) begin
         spi_state_q <= SPI_IDLE;
         acc57_q     <= 1'b0;
         sck_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         ph_q        <= 4'd0;
         tx_q        <= 8'hFF;
         rx_sh_q     <= 8'hFF;
         rx_byte_q   <= 8'hFF;
         rd_hold_q   <= 8'hFF;
      end else begin
         acc57_q <= acc57_s;
         if (start_s) begin
            rd_hold_q <= rx_byte_q;
         end
         if (io_wr_s && sel_77_s) begin
            cs_n_q <= cpu_if.xd_wr[1];
         end
         case (spi_state_q)
            SPI_IDLE: begin
               if (start_s) begin
                  spi_state_q <= SPI_XFER;
                  tx_q        <= cpu_if.n_wr ? 8'hFF : cpu_if.xd_wr;
                  ph_q        <= 4'd0;
                  sck_q       <= 1'b0;
               end
            end
            SPI_XFER: begin
               sck_q <= ~sck_q;
               ph_q  <= ph_q + 4'd1;
               if (!sck_q) begin
                  rx_sh_q <= {rx_sh_q[6:0], sd_miso_i};
               end else begin
                  tx_q <= {tx_q[6:0], 1'b1};
               end
               if (ph_q == 4'd15) begin
                  spi_state_q <= SPI_IDLE;
                  rx_byte_q   <= rx_sh_q;
               end
            end
            default: spi_state_q <= SPI_IDLE;
         endcase
      end
   end

   assign sd_sck_o  = sck_q;
   assign sd_mosi_o = tx_q[7];
   assign sd_cs_n_o = cs_n_q;
`else
   logic unused_sd_s;
   assign unused_sd_s = sd_miso_i ^ sd_cd_i;
   assign sd_sck_o    = 1'b0;
   assign sd_mosi_o   = 1'b1;
   assign sd_cs_n_o   = 1'b1;
`endif

   // Readable I/O ports
   always_comb begin
      port_rd_s   = 1'b0;
      port_data_s = 8'hFF;
      if (sel_fe_s) begin
         port_rd_s   = 1'b1;
         port_data_s = {1'b1, tape_in_i, 1'b1, kd_i};
      end else if (sel_1f_s) begin
         port_rd_s   = 1'b1;
         port_data_s = {3'b000, ~n_joy_b2_i, 4'b0000};
      end
`ifdef ZX_ULA_SD_EN
      else if (sel_77_s) begin
         port_rd_s   = 1'b1;
         port_data_s = {7'b0000000, ~sd_cd_i};
      end else if (sel_57_s) begin
         port_rd_s   = 1'b1;
         port_data_s = rd57_data_s;
      end
`endif
      else begin
         port_rd_s   = 1'b0;
         port_data_s = 8'hFF;
      end
   end

   assign cpu_if.dout  = (io_rd_s & port_rd_s) | ram_rd_s;
   assign cpu_if.xd_rd = ram_rd_s ? vd_i : port_data_s;
endmodule

// File: tb/tb_zx_ula_core.sv
// Directed/randomized bench for zx_ula_core with a small frame geometry and a behavioural reference model.
module tb_zx_ula_core;
   localparam int H = 16;
   localparam int V = 8;
   localparam int IL = 4;
   localparam int FRAME = H * V * 8;

   logic clk28 = 1'b0;
   logic rst;
   always #5 clk28 = ~clk28;

   zx_ula_core_if bus();

   logic        clkcpu;
   logic [18:0] va;
   logic [7:0]  vd_i, vd_o;
   logic        vdout;
   logic [3:0]  ra;
   logic        n_romcs, n_vrd, n_vwr, n_int, n_nmi;
   logic        n_magic, tape_in, n_joy_b2, sd_cd, sd_miso, sd_mosi, sd_sck, sd_cs_n;
   logic [4:0]  kd;
   logic [2:0]  border;
   logic        beeper;

   int n_checks = 0;
   int n_fail   = 0;

   assign sd_miso = sd_mosi;

   zx_ula_core #(.H_TSTATES(H), .V_LINES(V), .INT_LEN(IL)) dut (
      .clk28_i(clk28), .rst_i(rst), .clkcpu_o(clkcpu), .cpu_if(bus.slave),
      .va_o(va), .vd_i(vd_i), .vd_o(vd_o), .vdout_o(vdout), .ra_o(ra),
      .n_romcs_o(n_romcs), .n_vrd_o(n_vrd), .n_vwr_o(n_vwr), .n_int_o(n_int), .n_nmi_o(n_nmi),
      .n_magic_i(n_magic), .tape_in_i(tape_in), .kd_i(kd), .n_joy_b2_i(n_joy_b2),
      .sd_cd_i(sd_cd), .sd_miso_i(sd_miso), .sd_mosi_o(sd_mosi), .sd_sck_o(sd_sck),
      .sd_cs_n_o(sd_cs_n), .border_o(border), .beeper_o(beeper)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory map of the 128K machine: window 1 -> bank 5, window 2 -> bank 2, window 3 -> #7FFD bank
   function automatic logic [18:0] exp_va(input int a, input int p);
      int bank;
      case (a / 16384)
         1:       bank = 5;
         2:       bank = 2;
         default: bank = (p / 64) * 8 + (p % 8);
      endcase
      return 19'(bank * 16384 + a % 16384);
   endfunction

   task automatic bus_idle();
      bus.n_rd = 1'b1; bus.n_wr = 1'b1; bus.n_mreq = 1'b1;
      bus.n_m1 = 1'b1; bus.n_iorqge = 1'b1; bus.n_rfsh = 1'b1;
   endtask

   task automatic io_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk28);
      bus.xa = a; bus.xd_wr = d; bus.n_iorqge = 1'b0; bus.n_wr = 1'b0;
      repeat (3) @(negedge clk28);
      bus_idle();
   endtask

   task automatic io_read(input logic [15:0] a);
      @(negedge clk28);
      bus.xa = a; bus.n_iorqge = 1'b0; bus.n_rd = 1'b0;
      #1;
   endtask

   task automatic mem_cycle(input logic [15:0] a, input logic wr, input logic [7:0] d);
      @(negedge clk28);
      bus.xa = a; bus.xd_wr = d; bus.n_mreq = 1'b0;
      if (wr) bus.n_wr = 1'b0;
      else    bus.n_rd = 1'b0;
      #1;
   endtask

   task automatic end_cycle();
      @(negedge clk28);
      bus_idle();
   endtask

   initial begin
      logic [7:0]  m_p7ffd, v, dv, ex;
      logic [15:0] a;
      int          low, highs, rises, prev;
      int          falls[$];

      bus_idle();
      bus.xa = 16'h0000; bus.xd_wr = 8'h00;
      rst = 1'b1; n_magic = 1'b1; tape_in = 1'b0; kd = 5'h1F; n_joy_b2 = 1'b1; sd_cd = 1'b0; vd_i = 8'h00;
      m_p7ffd = 8'h00;
      repeat (4) @(negedge clk28);
      chk("rst_n_int", n_int, 0);
      chk("rst_n_nmi", n_nmi, 1);
      chk("rst_border", border, 0);
      chk("rst_beeper", beeper, 0);
      chk("rst_clkcpu", clkcpu, 0);
      chk("rst_sd_cs_n", sd_cs_n, 1);
      chk("rst_sd_sck", sd_sck, 0);
      chk("rst_sd_mosi", sd_mosi, 1);
      rst = 1'b0;

      // Frame: INT low for IL T-states per frame, one falling edge every FRAME clk28
      low = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk28);
         if (!n_int) low++;
      end
      chk("int_low_cycles", low, IL * 8);
      prev = n_int;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk28);
         if (prev == 1 && n_int == 1'b0) falls.push_back(i);
         prev = n_int;
      end
      chk("int_fall_count", falls.size(), 2);
      if (falls.size() == 2) chk("int_period", falls[1] - falls[0], FRAME);

      highs = 0; rises = 0; prev = clkcpu;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk28);
         if (clkcpu) highs++;
         if (prev == 0 && clkcpu == 1'b1) rises++;
         prev = clkcpu;
      end
      chk("clkcpu_high", highs, 32);
      chk("clkcpu_rises", rises, 8);

      // Port #FE read: directed value then random keyboard/tape
      kd = 5'b10101; tape_in = 1'b1;
      io_read(16'h00FE);
      chk("fe_rd_data", bus.xd_rd, 8'hF5);
      chk("fe_rd_dout", bus.dout, 1);
      end_cycle();
      for (int i = 0; i < 4; i++) begin
         kd = 5'($urandom); tape_in = 1'($urandom);
         io_read({8'($urandom), 8'hFE});
         chk("fe_rd_rand", bus.xd_rd, 128 + tape_in * 64 + 32 + kd);
         end_cycle();
      end
      for (int i = 0; i < 2; i++) begin
         n_joy_b2 = 1'(i);
         io_read(16'h001F);
         chk("1f_rd_data", bus.xd_rd, (1 - i) * 16);
         chk("1f_rd_dout", bus.dout, 1);
         end_cycle();
      end
      io_read(16'h7FFD);
      chk("7ffd_rd_dout", bus.dout, 0);
      end_cycle();
      @(negedge clk28);
      bus.xa = 16'h00FE; bus.n_m1 = 1'b0; bus.n_iorqge = 1'b0; bus.n_rd = 1'b0;
      #1 chk("inta_dout", bus.dout, 0);
      end_cycle();

      // Port #FE write
      for (int i = 0; i < 3; i++) begin
         v = 8'($urandom);
         io_write({8'($urandom), 8'hFE}, v);
         #1;
         chk("fe_border", border, v % 8);
         chk("fe_beeper", beeper, (v / 16) % 2);
      end

      // Paging: #13 selects bank 3 and ROM 1
      io_write(16'h7FFD, 8'h13); m_p7ffd = 8'h13;
      vd_i = 8'h5A;
      mem_cycle(16'hC000, 1'b0, 8'h00);
      chk("p13_va", va, 19'h0C000);
      chk("p13_ra", ra, 1);
      chk("p13_n_vrd", n_vrd, 0);
      chk("p13_xd", bus.xd_rd, 8'h5A);
      chk("p13_dout", bus.dout, 1);
      end_cycle();
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom) & 8'hDF;
         io_write(16'h7FFD, v);
         m_p7ffd = v;
         a = 16'($urandom_range(16'h4000, 16'hFFFF));
         dv = 8'($urandom); vd_i = dv;
         mem_cycle(a, 1'b0, 8'h00);
         chk("rd_va", va, exp_va(a, m_p7ffd));
         chk("rd_ra", ra, (m_p7ffd / 16) % 2);
         chk("rd_n_romcs", n_romcs, 1);
         chk("rd_n_vrd", n_vrd, 0);
         chk("rd_xd", bus.xd_rd, dv);
         chk("rd_dout", bus.dout, 1);
         chk("rd_vdout", vdout, 0);
         end_cycle();
         a = 16'($urandom_range(16'h4000, 16'hFFFF));
         dv = 8'($urandom);
         mem_cycle(a, 1'b1, dv);
         chk("wr_va", va, exp_va(a, m_p7ffd));
         chk("wr_n_vwr", n_vwr, 0);
         chk("wr_vdout", vdout, 1);
         chk("wr_vd", vd_o, dv);
         chk("wr_dout", bus.dout, 0);
         end_cycle();
      end
      a = 16'($urandom_range(0, 16'h3FFF));
      mem_cycle(a, 1'b0, 8'h00);
      chk("rom_n_romcs", n_romcs, 0);
      chk("rom_n_vrd", n_vrd, 1);
      chk("rom_dout", bus.dout, 0);
      end_cycle();
      @(negedge clk28);
      bus.xa = 16'h8000; bus.n_mreq = 1'b0; bus.n_rfsh = 1'b0; bus.n_rd = 1'b0;
      #1 chk("rfsh_n_vrd", n_vrd, 1);
      chk("rfsh_dout", bus.dout, 0);
      end_cycle();

      // Lock: #20 freezes paging, later #07 is ignored
      io_write(16'h7FFD, 8'h20);
      if (m_p7ffd[5] == 1'b0) m_p7ffd = 8'h20;
      io_write(16'h7FFD, 8'h07);
      if (m_p7ffd[5] == 1'b0) m_p7ffd = 8'h07;
      mem_cycle(16'hC123, 1'b0, 8'h00);
      chk("lock_va", va, exp_va(16'hC123, m_p7ffd));
      chk("lock_ra", ra, 0);
      end_cycle();

      // Magic NMI
      @(negedge clk28); n_magic = 1'b0;
      repeat (3) @(negedge clk28);
      n_magic = 1'b1;
      repeat (2) @(negedge clk28);
      chk("nmi_set", n_nmi, 0);
      @(negedge clk28);
      bus.xa = 16'h0038; bus.n_m1 = 1'b0; bus.n_mreq = 1'b0; bus.n_rd = 1'b0;
      end_cycle();
      #1 chk("nmi_other_fetch", n_nmi, 0);
      @(negedge clk28);
      bus.xa = 16'h0066; bus.n_m1 = 1'b0; bus.n_mreq = 1'b0; bus.n_rd = 1'b0;
      end_cycle();
      #1 chk("nmi_clear", n_nmi, 1);
      @(negedge clk28); n_magic = 1'b0;
      @(negedge clk28);
      @(negedge clk28);
      bus.xa = 16'h0066; bus.n_m1 = 1'b0; bus.n_mreq = 1'b0; bus.n_rd = 1'b0;
      end_cycle();
      n_magic = 1'b1;
      #1 chk("nmi_edge_wins", n_nmi, 0);
      @(negedge clk28);
      bus.xa = 16'h0066; bus.n_m1 = 1'b0; bus.n_mreq = 1'b0; bus.n_rd = 1'b0;
      end_cycle();
      #1 chk("nmi_clear2", n_nmi, 1);

`ifdef ZX_ULA_SD_EN
      io_write(16'h0077, 8'h00);
      #1 chk("sd_cs_low", sd_cs_n, 0);
      for (int i = 0; i < 2; i++) begin
         sd_cd = 1'(i);
         io_read(16'h0077);
         chk("sd_77_rd", bus.xd_rd, 1 - i);
         end_cycle();
      end
      io_write(16'h0057, 8'hA5);
      repeat (20) @(negedge clk28);
      io_read(16'h0057);
      chk("sd_loop_a5", bus.xd_rd, 8'hA5);
      chk("sd_loop_dout", bus.dout, 1);
      end_cycle();
      repeat (20) @(negedge clk28);
      io_read(16'h0057);
      chk("sd_rd_ff", bus.xd_rd, 8'hFF);
      end_cycle();
      repeat (20) @(negedge clk28);
      v = 8'($urandom); dv = 8'($urandom);
      io_write(16'h0057, v);
      io_write(16'h0057, dv);
      repeat (20) @(negedge clk28);
      io_read(16'h0057);
      chk("sd_busy_ignore", bus.xd_rd, v);
      end_cycle();
      repeat (20) @(negedge clk28);
      io_write(16'h0057, 8'h3C);
      rst = 1'b1;
      repeat (2) @(negedge clk28);
      chk("sd_abort_sck", sd_sck, 0);
      chk("sd_abort_mosi", sd_mosi, 1);
      chk("sd_abort_cs", sd_cs_n, 1);
      rst = 1'b0;
      io_read(16'h0057);
      chk("sd_abort_rx", bus.xd_rd, 8'hFF);
      end_cycle();
      repeat (20) @(negedge clk28);
`else
      io_write(16'h0057, 8'hA5);
      #1 chk("nosd_sck", sd_sck, 0);
      chk("nosd_mosi", sd_mosi, 1);
      chk("nosd_cs", sd_cs_n, 1);
      io_read(16'h0057);
      chk("nosd_57_dout", bus.dout, 0);
      end_cycle();
      io_read(16'h0077);
      chk("nosd_77_dout", bus.dout, 0);
      end_cycle();
`endif
      ex = 8'hFF;
      io_read(16'h00FE);
      chk("final_fe_dout", bus.dout, ex[0]);
      end_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
